// File: rtl/local_injector_pkg.sv
// Shared mesh parameters, port/state enums and the injected packet layout
// used by the local traffic injector and its queue.
package global_params;

  localparam int MESH_SIDE  = 4;
  localparam int DATA_WIDTH = 16;
  localparam int COORD_W    = $clog2(MESH_SIDE);
  localparam int TS_W       = DATA_WIDTH - 8;
  localparam int CNT_W      = 32;

  typedef enum logic [2:0] {NORTH, EAST, SOUTH, WEST, LOCAL} port_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } inj_state_e;

  typedef struct packed {
    logic                  sdx;
    logic                  sdy;
    logic [COORD_W-1:0]    dx;
    logic [COORD_W-1:0]    dy;
    logic [DATA_WIDTH-1:0] data;
  } inj_pkt_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/local_injector_fifo.sv
// Synchronous FIFO with registered storage; head is the oldest entry and a
// push into a full queue is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign empty = (r_count == '0);
  assign full  = (r_count == FULL_CNT);
  assign count = r_count;
  assign head  = r_mem[r_rptr];

  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= din;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/local_injector.sv
// Pseudo-random traffic source for a mesh router LOCAL port: an LFSR decides
// when and where to inject, packets are queued and offered with valid/ready.
module local_injector
  import global_params::*;
#(
  parameter int          NODE_X     = 0,
  parameter int          NODE_Y     = 0,
  parameter int          INJ_THRESH = 13,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  output logic                  out_sdx,
  output logic                  out_sdy,
  output logic [COORD_W-1:0]    out_dx,
  output logic [COORD_W-1:0]    out_dy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  in_ready,
  output logic                  busy,
  output logic [CNT_W-1:0]      cnt_gen,
  output logic [CNT_W-1:0]      cnt_sent,
  output logic [CNT_W-1:0]      cnt_drop,
  output inj_state_e            dbg_state
);

  // Handshake: a packet transfers in every cycle where out_valid && in_ready
  // are both high at the rising edge; out_* hold while out_valid && !in_ready.

  localparam int QAW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] THRESH_C = (INJ_THRESH >= 128) ? 8'd128 :
                                    (INJ_THRESH <= 0)   ? 8'd0   : 8'(INJ_THRESH);
  localparam logic [COORD_W-1:0] OWN_X = COORD_W'(NODE_X);
  localparam logic [COORD_W-1:0] OWN_Y = COORD_W'(NODE_Y);

  inj_state_e       r_state;
  inj_state_e       w_state_next;
  logic [15:0]      r_lfsr;
  logic             w_lfsr_fb;
  logic [TS_W-1:0]  r_ts;
  logic [CNT_W-1:0] r_cnt_gen;
  logic [CNT_W-1:0] r_cnt_sent;
  logic [CNT_W-1:0] r_cnt_drop;

  logic               w_gen;
  logic               w_pop;
  logic               w_drop;
  logic               w_will_empty;
  logic [COORD_W-1:0] w_dest_x;
  logic [COORD_W-1:0] w_dest_y;
  inj_pkt_t           w_new_pkt;
  inj_pkt_t           w_head;
  inj_pkt_t           w_out;
  logic               w_full;
  logic               w_empty;
  logic [QAW:0]       w_count;

  assign w_gen     = (r_state == ST_RUN) && ({1'b0, r_lfsr[6:0]} < THRESH_C);
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  assign w_dest_x = r_lfsr[8 +: COORD_W];
  assign w_dest_y = r_lfsr[12 +: COORD_W];

  assign w_new_pkt.sdx  = (w_dest_x < OWN_X);
  assign w_new_pkt.sdy  = (w_dest_y < OWN_Y);
  assign w_new_pkt.dx   = w_dest_x;
  assign w_new_pkt.dy   = w_dest_y;
  assign w_new_pkt.data = {4'(NODE_X), 4'(NODE_Y), r_ts};

  assign w_pop  = !w_empty && in_ready;
  assign w_drop = w_gen && w_full && !w_pop;
  // Leave DRAIN in the same cycle the last queued packet is accepted.
  assign w_will_empty = w_empty || ((w_count == (QAW+1)'(1)) && w_pop && !w_gen);

  sync_fifo #(
    .WIDTH ($bits(inj_pkt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_gen),
    .pop   (w_pop),
    .din   (w_new_pkt),
    .head  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (enable) w_state_next = ST_RUN;
      ST_RUN:   if (!enable) w_state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (enable)            w_state_next = ST_RUN;
        else if (w_will_empty) w_state_next = ST_IDLE;
      end
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_lfsr     <= LFSR_SEED;
      r_ts       <= '0;
      r_cnt_gen  <= '0;
      r_cnt_sent <= '0;
      r_cnt_drop <= '0;
    end else begin
      r_state    <= w_state_next;
      r_lfsr     <= {r_lfsr[14:0], w_lfsr_fb};
      r_ts       <= r_ts + 1'b1;
      r_cnt_gen  <= sat_inc(r_cnt_gen, w_gen);
      r_cnt_sent <= sat_inc(r_cnt_sent, w_pop);
      r_cnt_drop <= sat_inc(r_cnt_drop, w_drop);
    end
  end

  // Fields read as zero whenever nothing is offered.
  assign w_out     = w_empty ? '0 : w_head;
  assign out_sdx   = w_out.sdx;
  assign out_sdy   = w_out.sdy;
  assign out_dx    = w_out.dx;
  assign out_dy    = w_out.dy;
  assign out_data  = w_out.data;
  assign out_valid = !w_empty;
  assign busy      = (r_state != ST_IDLE);
  assign cnt_gen   = r_cnt_gen;
  assign cnt_sent  = r_cnt_sent;
  assign cnt_drop  = r_cnt_drop;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_local_injector.sv
// Scoreboard bench: a reference model pushes expected packets as they are
// generated; the monitor compares queue head, counters and state every cycle.
module tb_local_injector;
  import global_params::*;

  localparam int NX    = 2;
  localparam int NY    = 1;
  localparam int DEPTH = 4;
  localparam int PW    = $bits(inj_pkt_t);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic in_ready = 1'b0;

  logic                  out_sdx, out_sdy, out_valid, busy;
  logic [COORD_W-1:0]    out_dx, out_dy;
  logic [DATA_WIDTH-1:0] out_data;
  logic [31:0]           cnt_gen, cnt_sent, cnt_drop;
  inj_state_e            dbg_state;

  logic                  b_sdx, b_sdy, b_valid, b_busy;
  logic                  b_ready = 1'b1;
  logic [COORD_W-1:0]    b_dx, b_dy;
  logic [DATA_WIDTH-1:0] b_data;
  logic [31:0]           b_gen, b_sent, b_drop;
  inj_state_e            b_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [PW-1:0] exp_q[$];

  logic [15:0]  m_lfsr = 16'hACE1;
  logic [7:0]   m_ts = '0;
  inj_state_e   m_state = ST_IDLE;
  logic [31:0]  m_gen = '0, m_sent = '0, m_drop = '0;
  logic [3:0]   seen_dx = '0;

  logic [15:0]  d_lfsr = 16'hACE1;
  inj_state_e   d_state = ST_IDLE;
  logic [31:0]  d_gen = '0;
  logic         d_occ = 1'b0;

  local_injector #(
    .NODE_X(NX), .NODE_Y(NY), .INJ_THRESH(128), .LFSR_SEED(16'hACE1), .FIFO_DEPTH(DEPTH)
  ) u_dut (
    .clk(clk), .rst(rst), .enable(enable),
    .out_sdx(out_sdx), .out_sdy(out_sdy), .out_dx(out_dx), .out_dy(out_dy),
    .out_data(out_data), .out_valid(out_valid), .in_ready(in_ready), .busy(busy),
    .cnt_gen(cnt_gen), .cnt_sent(cnt_sent), .cnt_drop(cnt_drop), .dbg_state(dbg_state)
  );

  local_injector u_dut_dflt (
    .clk(clk), .rst(rst), .enable(enable),
    .out_sdx(b_sdx), .out_sdy(b_sdy), .out_dx(b_dx), .out_dy(b_dy),
    .out_data(b_data), .out_valid(b_valid), .in_ready(b_ready), .busy(b_busy),
    .cnt_gen(b_gen), .cnt_sent(b_sent), .cnt_drop(b_drop), .dbg_state(b_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max_cycles);
    int i = 0;
    while (busy && i < max_cycles) begin
      step(1);
      i++;
    end
    check("idle_timeout", busy, 1'b0);
  endtask

  // monitor + reference model, evaluated mid-cycle on settled signals
  always @(negedge clk) begin
    int        occ;
    logic      pop, gen, gen2;
    inj_pkt_t  pkt, act;
    if (rst) begin
      m_lfsr = 16'hACE1; m_ts = '0; m_state = ST_IDLE;
      m_gen = '0; m_sent = '0; m_drop = '0;
      exp_q.delete();
      d_lfsr = 16'hACE1; d_state = ST_IDLE; d_gen = '0; d_occ = 1'b0;
    end else begin
      occ = exp_q.size();
      check("out_valid", out_valid, occ != 0);
      check("busy", busy, m_state != ST_IDLE);
      check("state", dbg_state, m_state);
      check("cnt_gen", cnt_gen, m_gen);
      check("cnt_sent", cnt_sent, m_sent);
      check("cnt_drop", cnt_drop, m_drop);
      pop = (occ != 0) && in_ready;
      if (occ != 0) begin
        act = {out_sdx, out_sdy, out_dx, out_dy, out_data};
        check("head", act, exp_q[0]);
        seen_dx[act.dx] = 1'b1;
        if (pop) begin
          void'(exp_q.pop_front());
          m_sent++;
        end
      end
      gen = (m_state == ST_RUN);
      if (gen) begin
        pkt.dx   = m_lfsr[9:8];
        pkt.dy   = m_lfsr[13:12];
        pkt.sdx  = (pkt.dx < NX);
        pkt.sdy  = (pkt.dy < NY);
        pkt.data = {4'(NX), 4'(NY), m_ts};
        m_gen++;
        if (occ < DEPTH || pop) exp_q.push_back(pkt);
        else m_drop++;
      end
      case (m_state)
        ST_IDLE:  if (enable) m_state = ST_RUN;
        ST_RUN:   if (!enable) m_state = ST_DRAIN;
        default: begin
          if (enable)                m_state = ST_RUN;
          else if (exp_q.size() == 0) m_state = ST_IDLE;
        end
      endcase
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      m_ts++;

      // default-threshold instance, always ready: at most one packet resident
      check("dflt_cnt_gen", b_gen, d_gen);
      check("dflt_valid", b_valid, d_occ);
      gen2 = (d_state == ST_RUN) && (d_lfsr[6:0] < 7'd13);
      d_occ = gen2;
      if (gen2) d_gen++;
      case (d_state)
        ST_IDLE:  if (enable) d_state = ST_RUN;
        ST_RUN:   if (!enable) d_state = ST_DRAIN;
        default:  d_state = enable ? ST_RUN : ST_IDLE;
      endcase
      d_lfsr = {d_lfsr[14:0], d_lfsr[15] ^ d_lfsr[13] ^ d_lfsr[12] ^ d_lfsr[10]};
    end
  end

  // stimulus driver
  initial begin
    logic [PW-1:0] snap;
    logic [15:0]   pat;
    pat = 16'b1011_0010_1110_0101;

    rst = 1'b1; enable = 1'b0; in_ready = 1'b0;
    step(3);
    check("rst_valid", out_valid, 1'b0);
    check("rst_gen", cnt_gen, 32'd0);
    check("rst_sent", cnt_sent, 32'd0);
    check("rst_drop", cnt_drop, 32'd0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;

    // backpressure: 10 generates into a depth-4 queue
    enable = 1'b1;
    step(2);
    check("bp_first_valid", out_valid, 1'b1);
    snap = {out_sdx, out_sdy, out_dx, out_dy, out_data};
    step(9);
    check("bp_gen", cnt_gen, 32'd10);
    check("bp_drop", cnt_drop, 32'd6);
    check("bp_stable", {out_sdx, out_sdy, out_dx, out_dy, out_data}, snap);

    // full queue with simultaneous push/pop
    in_ready = 1'b1;
    step(5);
    check("fp_drop", cnt_drop, 32'd6);
    check("fp_sent", cnt_sent, 32'd5);
    check("fp_gen", cnt_gen, 32'd15);
    check("fp_occ", cnt_gen - cnt_sent - cnt_drop, 32'd4);

    enable = 1'b0;
    wait_idle(20);
    check("d1_sent", cnt_sent, 32'd10);
    check("d1_gen", cnt_gen, 32'd16);

    // three queued packets, then drain
    enable = 1'b1; in_ready = 1'b0;
    step(3);
    enable = 1'b0;
    step(1);
    check("d2_state", dbg_state, ST_DRAIN);
    check("d2_gen", cnt_gen, 32'd19);
    in_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("d2_valid", out_valid, 1'b1);
      check("d2_node", out_data[DATA_WIDTH-1 -: 8], 8'h21);
      step(1);
    end
    check("d2_idle", dbg_state, ST_IDLE);
    check("d2_sent", cnt_sent, 32'd13);
    check("d2_empty", out_valid, 1'b0);

    // reset with two packets queued in DRAIN
    enable = 1'b1; in_ready = 1'b0;
    step(2);
    enable = 1'b0;
    step(1);
    check("mr_pre_state", dbg_state, ST_DRAIN);
    check("mr_pre_gen", cnt_gen, 32'd21);
    rst = 1'b1; in_ready = 1'b1;
    step(1);
    check("mr_valid", out_valid, 1'b0);
    check("mr_sent", cnt_sent, 32'd0);
    check("mr_gen", cnt_gen, 32'd0);
    check("mr_state", dbg_state, ST_IDLE);
    rst = 1'b0; in_ready = 1'b0;

    // mixed traffic with an irregular ready pattern
    enable = 1'b1;
    for (int i = 0; i < 48; i++) begin
      in_ready = pat[i % 16];
      step(1);
    end
    enable = 1'b0; in_ready = 1'b1;
    wait_idle(20);
    check("end_valid", out_valid, 1'b0);
    check("end_invariant", cnt_gen, cnt_sent + cnt_drop);
    check("seen_dx0", seen_dx[0], 1'b1);
    check("seen_dx2", seen_dx[2], 1'b1);
    check("seen_dx3", seen_dx[3], 1'b1);
    step(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/local_injector.md
LOCAL_INJECTOR -- requirements
Module: local_injector

Interface
REQ-001 Parameter NODE_X, default 0, mesh x coordinate of the attached router.
REQ-002 Parameter NODE_Y, default 0, mesh y coordinate of the attached router.
REQ-003 Parameter INJ_THRESH, default 13, injection threshold out of 128 (about 10 %).
REQ-004 Parameter LFSR_SEED, default 16'hACE1, nonzero seed for the 16-bit LFSR.
REQ-005 Parameter FIFO_DEPTH, default 4, injection queue depth; must be a power of two and at least 2.
REQ-006 Ports, one per line:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  traffic generation enable.
- out_sdx  out  1  sign of x delta toward the destination.
- out_sdy  out  1  sign of y delta toward the destination.
- out_dx  out  $clog2(MESH_SIDE)  destination x.
- out_dy  out  $clog2(MESH_SIDE)  destination y.
- out_data  out  DATA_WIDTH  packet payload.
- out_valid  out  1  packet offered to the router LOCAL input.
- in_ready  in  1  router LOCAL input can accept.
- busy  out  1  FSM not in IDLE.
- cnt_gen  out  32  packets generated.
- cnt_sent  out  32  packets accepted by the router.
- cnt_drop  out  32  packets dropped because the queue was full.

Function
REQ-007 The design SHALL have one clock, clk; reset rst SHALL be synchronous and active-high.
REQ-008 The 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every cycle that rst=0.
REQ-009 Timestamp: a (DATA_WIDTH-8)-bit free-running counter SHALL increment every cycle and wrap to 0.
REQ-010 Generate condition: state=RUN and lfsr[6:0] < INJ_THRESH.
- INJ_THRESH=0 never generates.
- INJ_THRESH>=128 generates every RUN cycle.
REQ-011 Generated packet fields:
- dest_x = lfsr[8 +: clog2(MESH_SIDE)].
- dest_y = lfsr[12 +: clog2(MESH_SIDE)].
- data = {NODE_X[3:0], NODE_Y[3:0], timestamp}.
- sdx = (dest_x < NODE_X); sdy = (dest_y < NODE_Y).
- Destination equal to own node is legal.
REQ-012 A generated packet SHALL be pushed into the FIFO in the same cycle.
- If the FIFO is full and no pop occurs that cycle, the packet SHALL be dropped and cnt_drop SHALL increment.
- Full with a simultaneous pop: the push SHALL succeed.
REQ-013 out_valid SHALL equal FIFO not-empty; the out_* fields SHALL present the FIFO head.
REQ-014 Pop SHALL occur on out_valid && in_ready, and cnt_sent SHALL increment that cycle.
REQ-015 While out_valid=1 and in_ready=0, all out_* fields SHALL hold stable.
REQ-016 Latency: a packet generated in cycle n into an empty FIFO SHALL show out_valid=1 in cycle n+1.
REQ-017 cnt_gen SHALL increment on every generate, including dropped packets; the invariant is cnt_gen = cnt_sent + cnt_drop + occupancy.
REQ-018 All counters SHALL saturate at 2^32-1.
REQ-019 FSM states and transitions:
- IDLE -> RUN when enable=1.
- RUN -> DRAIN when enable=0.
- DRAIN -> RUN when enable=1.
- DRAIN -> IDLE when the FIFO is empty.
- DRAIN performs no generation; it continues popping.
REQ-020 busy SHALL be 1 in RUN and in DRAIN.

Reset
REQ-021 When rst=1 the block SHALL:
- set state to IDLE;
- empty the FIFO (out_valid=0);
- set out_* fields and counters to 0;
- set the timestamp to 0;
- load the LFSR with LFSR_SEED.
REQ-022 Reset asserted mid-operation SHALL discard queued packets with no handshake, and out_valid SHALL be 0 from the next cycle.

Structure
REQ-023 The package global_params SHALL hold MESH_SIDE, DATA_WIDTH, the port enum NORTH..LOCAL, and a new packet struct inj_pkt_t {sdx, sdy, dx, dy, data}.
REQ-024 The queue SHALL be a sub-module sync_fifo (parameters WIDTH and DEPTH) with push, pop, full, empty and head outputs; the FSM, LFSR and counters SHALL reside in local_injector.

Verification
REQ-025 Reset: rst=1 for 3 cycles -> out_valid=0, all counters 0, busy=0.
REQ-026 Backpressure: INJ_THRESH=128, FIFO_DEPTH=4, in_ready=0 for 10 cycles -> cnt_gen=10, cnt_drop=6, out_* stable throughout.
REQ-027 Simultaneous full push/pop: FIFO full, in_ready=1, INJ_THRESH=128 -> occupancy stays 4, cnt_drop unchanged.
REQ-028 Drain: NODE_X=2, NODE_Y=1, 3 packets queued, then enable=0 with in_ready=1 -> 3 pops, IDLE after the third pop, every out_data[DW-1:DW-8]=8'h21.
REQ-029 Field check: dest_x=0 with NODE_X=2 -> out_sdx=1; dest_x=3 -> out_sdx=0; dest_x=NODE_X -> out_sdx=0.
REQ-030 Reset mid-drain: rst=1 with 2 packets queued -> next cycle out_valid=0, cnt_sent=0, state IDLE.
